// File: rtl/mag_window_avg_if.sv
// Sample/result bundle between the magnitude stage, the window averager and its consumer.
// The master drives samples and clear; the slave returns ready and the registered results.
interface mag_window_avg_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_mag;
  logic              in_ready;
  logic              clear;
  logic              out_valid;
  logic [DATA_W-1:0] out_avg;
  logic [DATA_W-1:0] out_peak;
  logic              out_full;
  logic              out_alarm;

  modport master (
    output in_valid, in_mag, clear,
    input  in_ready, out_valid, out_avg, out_peak, out_full, out_alarm
  );

  modport slave (
    input  in_valid, in_mag, clear,
    output in_ready, out_valid, out_avg, out_peak, out_full, out_alarm
  );
endinterface

// File: rtl/mag_window_avg.sv
// Sliding-window boxcar average over the last 2^LOG2_DEPTH magnitude samples,
// with peak tracking, a hysteretic alarm on the average and a swept clear.
module mag_window_avg #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int THRESH_HI  = 100,
  parameter int THRESH_LO  = 80
) (
  input  logic             clk,
  input  logic             rst,
  mag_window_avg_if.slave  bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0]   FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH-1:0] LAST_IDX = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [DATA_W-1:0]     THI      = DATA_W'(THRESH_HI);
  localparam logic [DATA_W-1:0]     TLO      = DATA_W'(THRESH_LO);

  typedef enum logic {S_RUN, S_CLEAR} state_t;

  state_t                  r_state, w_state_n;
  logic [DATA_W-1:0]       r_buf [DEPTH];
  logic [SUM_W-1:0]        r_sum;
  logic [LOG2_DEPTH-1:0]   r_wr_ptr;
  logic [LOG2_DEPTH-1:0]   r_clr_idx;
  logic [LOG2_DEPTH:0]     r_fill_cnt;
  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_out_avg;
  logic [DATA_W-1:0]       r_out_peak;
  logic                    r_out_full;
  logic                    r_out_alarm;

  logic                    w_in_ready;
  logic                    w_accept;
  logic [SUM_W-1:0]        w_sum_n;
  logic [LOG2_DEPTH:0]     w_fill_n;
  logic [DATA_W-1:0]       w_avg_n;
  logic                    w_full_n;
  logic                    w_buf_we;
  logic [LOG2_DEPTH-1:0]   w_buf_addr;
  logic [DATA_W-1:0]       w_buf_din;

  assign w_in_ready = (r_state == S_RUN) & ~bus.clear;
  assign w_accept   = bus.in_valid & w_in_ready;

  // The evicted entry is zero while the window fills, so one update rule covers fill and steady state.
  assign w_sum_n  = r_sum + SUM_W'(bus.in_mag) - SUM_W'(r_buf[r_wr_ptr]);
  assign w_fill_n = (r_fill_cnt == FULL_CNT) ? FULL_CNT : r_fill_cnt + 1'b1;
  assign w_avg_n  = w_sum_n[SUM_W-1:LOG2_DEPTH];
  assign w_full_n = (w_fill_n == FULL_CNT);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_n  = r_state;
    w_buf_we   = 1'b0;
    w_buf_addr = r_wr_ptr;
    w_buf_din  = bus.in_mag;
    case (r_state)
      S_RUN: begin
        if (bus.clear)     w_state_n = S_CLEAR;
        else if (w_accept) w_buf_we  = 1'b1;
      end
      S_CLEAR: begin
        w_buf_we   = 1'b1;
        w_buf_addr = r_clr_idx;
        w_buf_din  = '0;
        if (r_clr_idx == LAST_IDX) w_state_n = S_RUN;
      end
      default: w_state_n = S_RUN;
    endcase
  end

  // NOTE: the buffer is small and must read as zero after reset, so it is reset like ordinary registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_buf_we) begin
      r_buf[w_buf_addr] <= w_buf_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_clr_idx   <= '0;
      r_fill_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_avg   <= '0;
      r_out_peak  <= '0;
      r_out_full  <= 1'b0;
      r_out_alarm <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_out_valid <= 1'b0;
      if (r_state == S_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end else if (bus.clear) begin
        r_clr_idx   <= '0;
        r_sum       <= '0;
        r_wr_ptr    <= '0;
        r_fill_cnt  <= '0;
        r_out_avg   <= '0;
        r_out_peak  <= '0;
        r_out_full  <= 1'b0;
        r_out_alarm <= 1'b0;
      end else if (w_accept) begin
        r_sum       <= w_sum_n;
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_fill_cnt  <= w_fill_n;
        r_out_valid <= 1'b1;
        r_out_avg   <= w_avg_n;
        r_out_full  <= w_full_n;
        if (bus.in_mag > r_out_peak) r_out_peak <= bus.in_mag;
        // Alarm only arms on a full window; between the thresholds it keeps its last value.
        if (!w_full_n)          r_out_alarm <= 1'b0;
        else if (w_avg_n >= THI) r_out_alarm <= 1'b1;
        else if (w_avg_n <= TLO) r_out_alarm <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_avg   = r_out_avg;
  assign bus.out_peak  = r_out_peak;
  assign bus.out_full  = r_out_full;
  assign bus.out_alarm = r_out_alarm;
endmodule

// File: tb/tb_mag_window_avg.sv
// Directed bench for mag_window_avg: fill, wrap, hysteresis, clear, reset during clear, gapped input.
// Expected values are hand-computed for DEPTH=8, THRESH_HI=100, THRESH_LO=80.
module tb_mag_window_avg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mag_window_avg_if #(.DATA_W(8)) bus ();

  mag_window_avg #(
    .DATA_W(8), .LOG2_DEPTH(3), .THRESH_HI(100), .THRESH_LO(80)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input logic v, input logic [7:0] m, input logic c);
    bus.in_valid = v;
    bus.in_mag   = m;
    bus.clear    = c;
  endtask

  // Advance one rising edge and settle just after it, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] m);
    drive(1'b1, m, 1'b0);
    tick();
    drive(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 8'd77, 1'b0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_avg !== 8'd0) $display("FAIL reset_avg: got %0d want 0", bus.out_avg); else n_pass++;
    n_checks++; if (bus.out_peak !== 8'd0) $display("FAIL reset_peak: got %0d want 0", bus.out_peak); else n_pass++;
    n_checks++; if (bus.out_full !== 1'b0) $display("FAIL reset_full: got %0b want 0", bus.out_full); else n_pass++;
    n_checks++; if (bus.out_alarm !== 1'b0) $display("FAIL reset_alarm: got %0b want 0", bus.out_alarm); else n_pass++;
    drive(1'b0, 8'd0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_over_clear_ready: got %0b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_fill();
    int exp_avg[8] = '{0, 1, 1, 2, 3, 3, 4, 5};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(8'd5);
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL fill_valid[%0d]: got %0b want 1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_avg !== 8'(exp_avg[i])) $display("FAIL fill_avg[%0d]: got %0d want %0d", i, bus.out_avg, exp_avg[i]); else n_pass++;
      n_checks++; if (bus.out_full !== (i == 7)) $display("FAIL fill_full[%0d]: got %0b want %0b", i, bus.out_full, (i == 7)); else n_pass++;
      n_checks++; if (bus.out_peak !== 8'd5) $display("FAIL fill_peak[%0d]: got %0d want 5", i, bus.out_peak); else n_pass++;
      n_checks++; if (bus.out_alarm !== 1'b0) $display("FAIL fill_alarm[%0d]: got %0b want 0", i, bus.out_alarm); else n_pass++;
    end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL fill_idle_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_avg !== 8'd5) $display("FAIL fill_idle_avg: got %0d want 5", bus.out_avg); else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      send(8'd13);
      n_checks++; if (bus.out_avg !== 8'(6 + i)) $display("FAIL wrap_avg[%0d]: got %0d want %0d", i, bus.out_avg, 6 + i); else n_pass++;
    end
    n_checks++; if (bus.out_peak !== 8'd13) $display("FAIL wrap_peak: got %0d want 13", bus.out_peak); else n_pass++;
    n_checks++; if (bus.out_full !== 1'b1) $display("FAIL wrap_full: got %0b want 1", bus.out_full); else n_pass++;
  endtask

  task automatic test_hysteresis();
    int avg_120[8] = '{15, 30, 45, 60, 75, 90, 105, 120};
    int avg_90[8]  = '{116, 112, 108, 105, 101, 97, 93, 90};
    int avg_60[8]  = '{86, 82, 78, 75, 71, 67, 63, 60};
    int alm_60[8]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(8'd120);
      n_checks++; if (bus.out_avg !== 8'(avg_120[i])) $display("FAIL hys120_avg[%0d]: got %0d want %0d", i, bus.out_avg, avg_120[i]); else n_pass++;
      n_checks++; if (bus.out_alarm !== (i == 7)) $display("FAIL hys120_alarm[%0d]: got %0b want %0b", i, bus.out_alarm, (i == 7)); else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      send(8'd90);
      n_checks++; if (bus.out_avg !== 8'(avg_90[i])) $display("FAIL hys90_avg[%0d]: got %0d want %0d", i, bus.out_avg, avg_90[i]); else n_pass++;
      n_checks++; if (bus.out_alarm !== 1'b1) $display("FAIL hys90_alarm[%0d]: got %0b want 1", i, bus.out_alarm); else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      send(8'd60);
      n_checks++; if (bus.out_avg !== 8'(avg_60[i])) $display("FAIL hys60_avg[%0d]: got %0d want %0d", i, bus.out_avg, avg_60[i]); else n_pass++;
      n_checks++; if (bus.out_alarm !== 1'(alm_60[i])) $display("FAIL hys60_alarm[%0d]: got %0b want %0d", i, bus.out_alarm, alm_60[i]); else n_pass++;
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 3; i++) send(8'd50);
    drive(1'b1, 8'd200, 1'b1);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL clr_same_cycle_ready: got %0b want 0", bus.in_ready); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clr_edge_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_avg !== 8'd0) $display("FAIL clr_edge_avg: got %0d want 0", bus.out_avg); else n_pass++;
    n_checks++; if (bus.out_peak !== 8'd0) $display("FAIL clr_edge_peak: got %0d want 0", bus.out_peak); else n_pass++;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 8'd200, (c == 3));
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL clr_busy_ready[%0d]: got %0b want 0", c, bus.in_ready); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL clr_busy_valid[%0d]: got %0b want 0", c, bus.out_valid); else n_pass++;
    end
    drive(1'b0, 8'd0, 1'b0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL clr_done_ready: got %0b want 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      send(8'd40);
      n_checks++; if (bus.out_avg !== 8'(5 * (i + 1))) $display("FAIL clr_after_avg[%0d]: got %0d want %0d", i, bus.out_avg, 5 * (i + 1)); else n_pass++;
      n_checks++; if (bus.out_peak !== 8'd40) $display("FAIL clr_after_peak[%0d]: got %0d want 40", i, bus.out_peak); else n_pass++;
      n_checks++; if (bus.out_full !== 1'b0) $display("FAIL clr_after_full[%0d]: got %0b want 0", i, bus.out_full); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int avg_255[8] = '{31, 63, 95, 127, 159, 191, 223, 255};
    do_reset();
    send(8'd100);
    send(8'd100);
    drive(1'b0, 8'd0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rmc_ready: got %0b want 1", bus.in_ready); else n_pass++;
    n_checks++; if ({bus.out_valid, bus.out_avg, bus.out_peak, bus.out_full, bus.out_alarm} !== 19'd0)
      $display("FAIL rmc_outputs: got %0h want 0", {bus.out_valid, bus.out_avg, bus.out_peak, bus.out_full, bus.out_alarm}); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      send(8'd255);
      n_checks++; if (bus.out_avg !== 8'(avg_255[i])) $display("FAIL rmc_avg[%0d]: got %0d want %0d", i, bus.out_avg, avg_255[i]); else n_pass++;
    end
    n_checks++; if (bus.out_alarm !== 1'b1) $display("FAIL rmc_alarm: got %0b want 1", bus.out_alarm); else n_pass++;
    n_checks++; if (bus.out_full !== 1'b1) $display("FAIL rmc_full: got %0b want 1", bus.out_full); else n_pass++;
  endtask

  task automatic test_gapped();
    logic v_pat[7]  = '{1, 0, 1, 1, 0, 0, 1};
    int   mags[4]   = '{10, 20, 30, 40};
    int   avgs[4]   = '{1, 3, 7, 12};
    int   k         = 0;
    int   pulses    = 0;
    int   cur_avg   = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (v_pat[i]) drive(1'b1, 8'(mags[k]), 1'b0);
      else          drive(1'b0, 8'hEE, 1'b0);
      tick();
      if (v_pat[i]) begin
        cur_avg = avgs[k];
        k++;
      end
      if (bus.out_valid === 1'b1) pulses++;
      n_checks++; if (bus.out_valid !== v_pat[i]) $display("FAIL gap_valid[%0d]: got %0b want %0b", i, bus.out_valid, v_pat[i]); else n_pass++;
      n_checks++; if (bus.out_avg !== 8'(cur_avg)) $display("FAIL gap_avg[%0d]: got %0d want %0d", i, bus.out_avg, cur_avg); else n_pass++;
    end
    drive(1'b0, 8'd0, 1'b0);
    n_checks++; if (pulses != 4) $display("FAIL gap_pulses: got %0d want 4", pulses); else n_pass++;
  endtask

  initial begin
    drive(1'b0, 8'd0, 1'b0);
    test_reset();
    test_fill();
    test_wrap();
    test_hysteresis();
    test_clear();
    test_reset_mid_clear();
    test_gapped();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
